vdma_irq_ctrl_nch: RTL and testbench
====================================

Name: vdma_irq_ctrl_nch

Overview:
- Parametrised N-source interrupt aggregator for the VDMA subsystem; successor to the fixed 5-source VDMA interrupt controller.
- Synchronises raw event lines and qualifies each one in per-source edge or level mode.
- Keeps a saturating per-source pending counter with sticky overflow flags, and drives a single processor interrupt.
- Optional interrupt coalescing by count threshold or timeout.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..32)
- CNT_W, 5, pending-counter width per source; saturates at 2^CNT_W-1
- SYNC_STAGES, 2, synchroniser flops on every event_i bit (>=2)
- COAL_W, 16, coalescing timer width

Ports:
- sys_clk_i  in  1  system clock
- rstn_i  in  1  reset, synchronous, active-low
- event_i  in  NUM_SRC  raw event lines, may be asynchronous
- vdma_ip_en_i  in  1  IP enable
- global_interrupt_en_i  in  1  global interrupt enable
- interrupt_en_i  in  NUM_SRC  per-source enable
- level_mode_i  in  NUM_SRC  1=level-qualified, 0=rising-edge-qualified
- interrupt_clear_i  in  NUM_SRC  per-bit 1-cycle pulse, acknowledges one pending event
- overflow_clear_i  in  NUM_SRC  per-bit pulse, clears sticky overflow
- coal_thresh_i  in  CNT_W  coalescing count threshold
- coal_timeout_i  in  COAL_W  coalescing timeout in cycles
- status_reg_o  out  NUM_SRC  1 while source pending count != 0
- pending_cnt_o  out  NUM_SRC*CNT_W  packed pending counts; source i at [i*CNT_W +: CNT_W]
- interrupt_o  out  1  processor interrupt, registered
- interrupt_overflow_o  out  NUM_SRC  sticky saturation flags

Behaviour:
- Reset: all state is synchronous to sys_clk_i, so rstn_i=0 takes effect at the next edge. While reset is applied, all outputs, synchroniser flops, counters and the timer are 0. Reset mid-operation discards all pending events.
- Sync: each event_i bit passes through SYNC_STAGES flops to give s[i], plus one history flop p[i].
- Qualification: gate g = vdma_ip_en_i & global_interrupt_en_i & interrupt_en_i[i].
  - Edge mode: q[i] = g & s[i] & !p[i].
  - Level mode: q[i] = g & s[i] & (cnt[i]==0). A line still high after the last clear re-arms one event.
- Counter update per source, one edge:
  - q only: cnt+1. If cnt is at max, it holds, the event is dropped, and overflow[i] is set.
  - clear only: cnt-1 if cnt!=0; a clear at 0 is ignored.
  - q and clear together: cnt 0 -> 1; otherwise unchanged.
- status_reg_o[i] and pending_cnt_o are registered and update on the same edge as cnt.
- Latency: event_i high first sampled at edge k gives status at edge k+SYNC_STAGES+1, and interrupt_o one edge later.
- Overflow: set and overflow_clear_i in the same cycle resolves to set. Only overflow_clear_i or reset clears the flag.
- interrupt_o (no coalescing) = registered OR over i of (status[i] & interrupt_en_i[i]) & vdma_ip_en_i & global_interrupt_en_i.
- Disabling any gate:
  - new events are dropped;
  - existing counts are retained and remain clearable;
  - interrupt_o deasserts on the next edge.
- Enable changes apply combinationally to qualification; no event is generated by an enable edge itself.

Optional Feature:
- Macro VDMA_IRQ_COALESCE_EN.
- When defined:
  - Timer counts up each cycle while any enabled source is pending and interrupt_o is 0.
  - Timer resets to 0 when no enabled source is pending.
  - interrupt_o asserts when any enabled source's cnt >= coal_thresh_i, or when timer == coal_timeout_i. The timer holds at that value.
  - interrupt_o deasserts when no enabled source is pending.
  - coal_thresh_i <= 1 or coal_timeout_i == 0 gives immediate assertion, as in the non-coalesced build.
- When not defined: coal_thresh_i and coal_timeout_i are present but ignored, and no timer logic is built.

Test Plan:
- Reset: drive rstn_i=0 for 3 cycles with all event_i=1 -> every output 0. After release, edge-mode sources with enables high count exactly 1.
- Edge counting: 3 pulses on event_i[2] (edge mode, enabled), then 3 clear pulses -> pending_cnt 1,2,3 then 2,1,0. interrupt_o falls 1 cycle after cnt reaches 0. A 4th clear leaves cnt at 0.
- Simultaneous: q and clear on source 0 in the same cycle at cnt=0 -> cnt=1; repeat at cnt=2 -> cnt stays 2.
- Saturation: CNT_W=5, 33 edges with no clears -> cnt=31, interrupt_overflow_o[i]=1. The flag stays set after clearing to 0, and drops only on an overflow_clear_i pulse.
- Level mode: hold event_i[1]=1 -> cnt=1 only. Clear -> cnt returns to 1 within 1 cycle while the line stays high. Drop the line, then clear -> cnt 0.
- Coalescing (macro on): thresh=4, timeout=100. 2 events -> interrupt_o rises exactly 100 cycles after the first pending. With a fresh sequence, 4 events within 10 cycles -> interrupt_o on the 4th count.

Source files
------------

// File: rtl/vdma_irq_ctrl_nch.sv
// vdma_irq_ctrl_nch: N-source VDMA interrupt aggregator.
// Raw event lines are synchronised and then qualified per source in edge or
// level mode. Each source has a saturating pending counter and a sticky
// overflow flag, and all sources drive one registered processor interrupt.
// Optional coalescing by count threshold or timeout is built only when the
// macro VDMA_IRQ_COALESCE_EN is defined. Without it, coal_thresh_i and
// coal_timeout_i are ignored.
module vdma_irq_ctrl_nch #(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COAL_W      = 16
) (
  input  logic                     sys_clk_i,
  input  logic                     rstn_i,
  input  logic [NUM_SRC-1:0]       event_i,
  input  logic                     vdma_ip_en_i,
  input  logic                     global_interrupt_en_i,
  input  logic [NUM_SRC-1:0]       interrupt_en_i,
  input  logic [NUM_SRC-1:0]       level_mode_i,
  input  logic [NUM_SRC-1:0]       interrupt_clear_i,
  input  logic [NUM_SRC-1:0]       overflow_clear_i,
  input  logic [CNT_W-1:0]         coal_thresh_i,
  input  logic [COAL_W-1:0]        coal_timeout_i,
  output logic [NUM_SRC-1:0]       status_reg_o,
  output logic [NUM_SRC*CNT_W-1:0] pending_cnt_o,
  output logic                     interrupt_o,
  output logic [NUM_SRC-1:0]       interrupt_overflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] hist_q;
  logic [NUM_SRC-1:0] qual_q;
  logic [NUM_SRC-1:0] s_w;
  logic [NUM_SRC-1:0] gate_w;
  logic [NUM_SRC-1:0] q_w;
  logic               ip_gate;

  logic [CNT_W-1:0]   cnt_q [NUM_SRC];
  logic [CNT_W-1:0]   cnt_d [NUM_SRC];
  logic [NUM_SRC-1:0] status_q;
  logic [NUM_SRC-1:0] status_d;
  logic [NUM_SRC-1:0] ovf_q;
  logic [NUM_SRC-1:0] ovf_set;
  logic               irq_q;
  logic               irq_d;

  assign ip_gate = vdma_ip_en_i & global_interrupt_en_i;
  assign gate_w  = interrupt_en_i & {NUM_SRC{ip_gate}};
  assign s_w     = sync_q[SYNC_STAGES-1];

  // Synchroniser chain, history flop and registered raw qualification.
  // The qualification register adds the cycle that places status at
  // k+SYNC_STAGES+1. The level-mode "count is zero" term is applied after this
  // register so that a held line re-arms on the cycle right after the last clear.
  always_ff @(posedge sys_clk_i) begin
    if (!rstn_i) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      hist_q <= '0;
      qual_q <= '0;
    end else begin
      sync_q[0] <= event_i;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      hist_q <= s_w;
      qual_q <= gate_w & ((level_mode_i & s_w) | (~level_mode_i & s_w & ~hist_q));
    end
  end

  // Per-source pending counter next state and overflow detection.
  always_comb begin
    cnt_d    = cnt_q;
    q_w      = '0;
    ovf_set  = '0;
    status_d = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      q_w[i] = qual_q[i] & gate_w[i] & (~level_mode_i[i] | (cnt_q[i] == '0));
      case ({q_w[i], interrupt_clear_i[i]})
        2'b10: begin
          if (cnt_q[i] == CNT_MAX) begin
            ovf_set[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        2'b01: begin
          if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
          end
        end
        2'b11: begin
          if (cnt_q[i] == '0) begin
            cnt_d[i] = CNT_ONE;
          end
        end
        default: begin
        end
      endcase
      status_d[i] = (cnt_d[i] != '0);
    end
  end

`ifdef VDMA_IRQ_COALESCE_EN
  logic [COAL_W-1:0] timer_q;
  logic [COAL_W-1:0] timer_d;
  logic              any_pend;
  logic              any_thr;

  // Coalescing decision. The timer runs only while something is pending and
  // the interrupt is low. Comparing against the next timer value makes the
  // interrupt rise on the edge where the timer reaches the timeout.
  always_comb begin
    any_pend = |(status_q & gate_w);
    any_thr  = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (status_q[i] && interrupt_en_i[i] && (cnt_q[i] >= coal_thresh_i)) begin
        any_thr = 1'b1;
      end
    end
    timer_d = '0;
    irq_d   = 1'b0;
    if (any_pend) begin
      timer_d = timer_q;
      if (!irq_q && (timer_q != coal_timeout_i)) begin
        timer_d = timer_q + COAL_W'(1);
      end
      irq_d = irq_q | any_thr | (timer_d == coal_timeout_i) | (coal_thresh_i <= CNT_ONE);
    end
  end

  // Coalescing timer register.
  always_ff @(posedge sys_clk_i) begin
    if (!rstn_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic unused_coal;
  assign unused_coal = ^{coal_thresh_i, coal_timeout_i};

  // Interrupt request: any enabled pending source with both global gates open.
  always_comb begin
    irq_d = |(status_q & interrupt_en_i) & ip_gate;
  end
`endif

  // Counter, status, sticky overflow and interrupt registers. A set and a clear
  // of the overflow flag on the same edge resolve to set.
  always_ff @(posedge sys_clk_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= '0;
      end
      status_q <= '0;
      ovf_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      status_q <= status_d;
      ovf_q    <= ovf_set | (ovf_q & ~overflow_clear_i);
      irq_q    <= irq_d;
    end
  end

  // Pack the per-source counters onto the flat output bus.
  always_comb begin
    pending_cnt_o = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      pending_cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign status_reg_o         = status_q;
  assign interrupt_o          = irq_q;
  assign interrupt_overflow_o = ovf_q;

endmodule

// File: tb/tb_vdma_irq_ctrl_nch.sv
// Self-checking bench for vdma_irq_ctrl_nch. A behavioural model tracks the
// sampled event history, the pending counts, the overflow flags and the
// interrupt. One process compares the DUT against the model every cycle, and
// directed sequences pin the model with literal expectations.
module tb_vdma_irq_ctrl_nch;
  localparam int NS   = 8;
  localparam int CW   = 5;
  localparam int SS   = 2;
  localparam int TW   = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NS-1:0]   ev, en, lvl, clr, oclr;
  logic            vip, gie;
  logic [CW-1:0]   thresh;
  logic [TW-1:0]   tmo;
  logic [NS-1:0]   status;
  logic [NS*CW-1:0] pcnt;
  logic            irq;
  logic [NS-1:0]   ovf;

  always #5 clk = ~clk;

  vdma_irq_ctrl_nch #(
    .NUM_SRC(NS), .CNT_W(CW), .SYNC_STAGES(SS), .COAL_W(TW)
  ) dut (
    .sys_clk_i(clk), .rstn_i(rstn), .event_i(ev),
    .vdma_ip_en_i(vip), .global_interrupt_en_i(gie),
    .interrupt_en_i(en), .level_mode_i(lvl),
    .interrupt_clear_i(clr), .overflow_clear_i(oclr),
    .coal_thresh_i(thresh), .coal_timeout_i(tmo),
    .status_reg_o(status), .pending_cnt_o(pcnt),
    .interrupt_o(irq), .interrupt_overflow_o(ovf)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int cnt_of(input int i);
    return int'(pcnt[i*CW +: CW]);
  endfunction

  // ---------------- behavioural model ----------------
  int m_cnt [NS];
  bit m_ovf [NS];
  bit m_stat[NS];
  bit m_qr  [NS];
  bit m_smp [NS][SS+1];   // m_smp[i][j] = event_i[i] sampled j edges ago
  bit m_irq;
  int m_timer;
  bit m_valid = 1'b0;

  always @(posedge clk) begin : model
    bit gates, pend, thr, g, q, c, s, p, set;
    if (!rstn) begin
      for (int i = 0; i < NS; i++) begin
        m_cnt[i] = 0; m_ovf[i] = 0; m_stat[i] = 0; m_qr[i] = 0;
        for (int j = 0; j <= SS; j++) m_smp[i][j] = 0;
      end
      m_irq = 0; m_timer = 0; m_valid = 1'b1;
    end else begin
      gates = vip & gie;
      pend = 0; thr = 0;
      for (int i = 0; i < NS; i++) begin
        if (m_stat[i] && en[i] && gates) begin
          pend = 1;
          if (m_cnt[i] >= int'(thresh)) thr = 1;
        end
      end
`ifdef VDMA_IRQ_COALESCE_EN
      if (!pend) begin
        m_timer = 0; m_irq = 0;
      end else begin
        if (!m_irq && m_timer != int'(tmo)) m_timer++;
        m_irq = m_irq || thr || (m_timer == int'(tmo)) || (thresh <= 1);
      end
`else
      m_irq = pend;
`endif
      for (int i = 0; i < NS; i++) begin
        g = gates & en[i];
        q = m_qr[i] & g & (lvl[i] ? (m_cnt[i] == 0) : 1'b1);
        c = clr[i];
        set = 0;
        if (q && !c) begin
          if (m_cnt[i] == CMAX) set = 1; else m_cnt[i]++;
        end else if (c && !q) begin
          if (m_cnt[i] > 0) m_cnt[i]--;
        end else if (q && c && m_cnt[i] == 0) begin
          m_cnt[i] = 1;
        end
        m_ovf[i]  = set | (m_ovf[i] & !oclr[i]);
        m_stat[i] = (m_cnt[i] != 0);
        s = m_smp[i][SS-1];
        p = m_smp[i][SS];
        m_qr[i] = g & (lvl[i] ? s : (s & !p));
        for (int j = SS; j > 0; j--) m_smp[i][j] = m_smp[i][j-1];
        m_smp[i][0] = ev[i];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin : compare
    logic [NS*CW-1:0] e_cnt;
    logic [NS-1:0] e_st, e_ov;
    #1;
    if (m_valid) begin
      for (int i = 0; i < NS; i++) begin
        e_cnt[i*CW +: CW] = CW'(m_cnt[i]);
        e_st[i] = m_stat[i];
        e_ov[i] = m_ovf[i];
      end
      chk("model_pending_cnt", 64'(pcnt), 64'(e_cnt));
      chk("model_status", 64'(status), 64'(e_st));
      chk("model_overflow", 64'(ovf), 64'(e_ov));
      chk("model_interrupt", 64'(irq), 64'(m_irq));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ev(input int i);
    ev[i] = 1'b1; @(negedge clk);
    ev[i] = 1'b0; @(negedge clk);
  endtask

  task automatic pulse_clr(input int i);
    clr[i] = 1'b1; @(negedge clk);
    clr[i] = 1'b0;
  endtask

  // Edge event whose counting edge coincides with a clear pulse.
  task automatic ev_with_clr(input int i);
    ev[i] = 1'b1; cyc(1);
    ev[i] = 1'b0; cyc(2);
    clr[i] = 1'b1; cyc(1);
    clr[i] = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int k, t_a, t_b;
    rstn = 1'b0; ev = '1; en = '1; lvl = '0; clr = '0; oclr = '0;
    vip = 1'b1; gie = 1'b1; thresh = CW'(1); tmo = '0;

    // reset with all events high
    cyc(3);
    chk("reset_cnt", 64'(pcnt), 64'd0);
    chk("reset_status", 64'(status), 64'd0);
    chk("reset_irq", 64'(irq), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    rstn = 1'b1;
    cyc(8);
    for (int i = 0; i < NS; i++) chk("post_reset_edge_cnt", 64'(cnt_of(i)), 64'd1);
    ev = '0;
    clr = '1; cyc(1); clr = '0;
    cyc(4);
    chk("all_cleared", 64'(pcnt), 64'd0);
    chk("irq_low_after_clear", 64'(irq), 64'd0);

    // edge counting on source 2
    for (int n = 1; n <= 3; n++) begin
      pulse_ev(2); cyc(2);
      chk("edge_cnt_up", 64'(cnt_of(2)), 64'(n));
    end
    chk("edge_irq_high", 64'(irq), 64'd1);
    for (int n = 2; n >= 0; n--) begin
      pulse_clr(2);
      chk("edge_cnt_down", 64'(cnt_of(2)), 64'(n));
    end
    chk("irq_still_high_at_zero", 64'(irq), 64'd1);
    cyc(1);
    chk("irq_falls_next_edge", 64'(irq), 64'd0);
    pulse_clr(2);
    chk("clear_at_zero_ignored", 64'(cnt_of(2)), 64'd0);

    // simultaneous event and clear on source 0
    ev_with_clr(0);
    chk("simul_at_zero", 64'(cnt_of(0)), 64'd1);
    pulse_ev(0); cyc(2);
    chk("simul_setup_two", 64'(cnt_of(0)), 64'd2);
    ev_with_clr(0); cyc(2);
    chk("simul_at_two", 64'(cnt_of(0)), 64'd2);
    pulse_clr(0); pulse_clr(0);
    chk("simul_cleared", 64'(cnt_of(0)), 64'd0);

    // saturation on source 3
    repeat (33) pulse_ev(3);
    cyc(3);
    chk("sat_cnt", 64'(cnt_of(3)), 64'(CMAX));
    chk("sat_ovf_set", 64'(ovf[3]), 64'd1);
    repeat (CMAX) pulse_clr(3);
    chk("sat_cleared_cnt", 64'(cnt_of(3)), 64'd0);
    cyc(2);
    chk("sat_ovf_sticky", 64'(ovf[3]), 64'd1);
    oclr[3] = 1'b1; cyc(1); oclr[3] = 1'b0;
    chk("sat_ovf_cleared", 64'(ovf[3]), 64'd0);

    // level mode on source 1
    lvl[1] = 1'b1; ev[1] = 1'b1;
    cyc(8);
    chk("level_one_only", 64'(cnt_of(1)), 64'd1);
    cyc(5);
    chk("level_still_one", 64'(cnt_of(1)), 64'd1);
    pulse_clr(1); cyc(1);
    chk("level_rearm", 64'(cnt_of(1)), 64'd1);
    ev[1] = 1'b0; cyc(5);
    pulse_clr(1); cyc(3);
    chk("level_dropped_cleared", 64'(cnt_of(1)), 64'd0);
    lvl[1] = 1'b0;

`ifdef VDMA_IRQ_COALESCE_EN
    // coalescing: timeout path, two events on source 5
    thresh = CW'(4); tmo = TW'(100);
    cyc(2);
    ev[5] = 1'b1; k = 0; t_a = -1; t_b = -1;
    while (t_b < 0 && k < 400) begin
      @(negedge clk); k++;
      ev[5] = (k == 2);
      if (t_a < 0 && status[5]) t_a = k;
      if (irq) t_b = k;
    end
    chk("coal_timeout_delay", 64'(t_b - t_a), 64'd100);
    chk("coal_timeout_cnt", 64'(cnt_of(5)), 64'd2);
    pulse_clr(5); pulse_clr(5); cyc(2);
    chk("coal_irq_drops", 64'(irq), 64'd0);

    // coalescing: threshold path, four events within ten cycles
    ev[5] = 1'b1; k = 0; t_a = -1; t_b = -1;
    while (t_b < 0 && k < 60) begin
      @(negedge clk); k++;
      ev[5] = (k == 2 || k == 4 || k == 6);
      if (t_a < 0 && cnt_of(5) == 4) t_a = k;
      if (irq) t_b = k;
    end
    chk("coal_thresh_delay", 64'(t_b - t_a), 64'd1);
    repeat (4) pulse_clr(5);
    cyc(2);
    chk("coal_thresh_cleared", 64'(irq), 64'd0);
    thresh = CW'(1); tmo = '0;
`endif

    // randomized phase
    for (int c = 0; c < 4000; c++) begin
      ev   = NS'($urandom) & NS'($urandom);
      clr  = NS'($urandom) & NS'($urandom) & NS'($urandom);
      oclr = ($urandom_range(0, 15) == 0) ? NS'($urandom) : '0;
      if ($urandom_range(0, 99) == 0) en = NS'($urandom) | NS'(8'h0F);
      if ($urandom_range(0, 199) == 0) lvl = NS'($urandom);
      vip = ($urandom_range(0, 49) != 0);
      gie = ($urandom_range(0, 49) != 0);
`ifdef VDMA_IRQ_COALESCE_EN
      if ($urandom_range(0, 299) == 0) begin
        thresh = CW'($urandom_range(0, 8));
        tmo    = TW'($urandom_range(0, 40));
      end
`endif
      if (c == 2000) rstn = 1'b0;
      if (c == 2003) rstn = 1'b1;
      @(negedge clk);
    end
    ev = '0; clr = '0; oclr = '0;
    cyc(4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
